// File: rtl/var_bank_sched.sv
// var_bank_sched: two-requester round-robin scheduler in front of a small
// bank of mixed-shape variables. Each grant runs one access through
// IDLE -> ACCESS -> RESP and produces exactly one response pulse.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a request; arbitration and capture of the winner
// ACCESS | gnt pulse to the winner; write commit / read sample at exit
// RESP   | rsp_valid pulse carrying read data or read-back
module var_bank_sched #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            reset_l,
  input  logic [1:0]      req,
  input  logic [1:0]      req_we,
  input  logic [5:0]      req_addr,
  input  logic [5:0]      req_idx,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      gnt,
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t         state_q, state_d;
  logic           rr_q, rr_d;
  logic           id_q, id_d;
  logic           we_q, we_d;
  logic [2:0]     addr_q, addr_d;
  logic [2:0]     idx_q, idx_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           err_q, err_d;

  logic           onebit_q, onebit_d;
  logic           onereg_q, onereg_d;
  logic [1:0]     a_p1_q, a_p1_d;
  logic [1:0]     a_sp1_q, a_sp1_d;
  logic [5:0]     a_p21_q, a_p21_d;
  logic [2:0]     a_u2_q, a_u2_d;
  logic [3:0]     a_p1u1_q, a_p1u1_d;
  logic [5:0]     a_p0u12_q, a_p0u12_d;

  logic           winner;
  logic           idx_ok;
  logic [DW-1:0]  cur_val;
  logic [DW-1:0]  elem_mask;
  logic [DW-1:0]  new_val;
  logic [DW-1:0]  ext_val;
  logic [5:0]     sel6;

  // Element lookup: legality, current value and width mask of the captured target
  always_comb begin
    idx_ok    = 1'b0;
    cur_val   = '0;
    elem_mask = '0;
    sel6      = '0;
    case (addr_q)
      3'd0: begin
        idx_ok    = (idx_q == 3'd0);
        cur_val   = {7'b0, onebit_q};
        elem_mask = 8'h01;
      end
      3'd1: begin
        idx_ok    = (idx_q == 3'd0);
        cur_val   = {7'b0, onereg_q};
        elem_mask = 8'h01;
      end
      3'd2: begin
        idx_ok    = (idx_q == 3'd0);
        cur_val   = {6'b0, a_p1_q};
        elem_mask = 8'h03;
      end
      3'd3: begin
        idx_ok    = (idx_q == 3'd0);
        cur_val   = {6'b0, a_sp1_q};
        elem_mask = 8'h03;
      end
      3'd4: begin
        idx_ok    = (idx_q == 3'd0);
        cur_val   = {2'b0, a_p21_q};
        elem_mask = 8'h3F;
      end
      3'd5: begin
        idx_ok    = (idx_q <= 3'd2);
        sel6      = 6'(a_u2_q) >> idx_q;
        cur_val   = {7'b0, sel6[0]};
        elem_mask = 8'h01;
      end
      3'd6: begin
        idx_ok    = (idx_q <= 3'd1);
        sel6      = 6'(a_p1u1_q) >> {idx_q[1:0], 1'b0};
        cur_val   = {6'b0, sel6[1:0]};
        elem_mask = 8'h03;
      end
      default: begin
        idx_ok    = (idx_q <= 3'd5);
        sel6      = a_p0u12_q >> idx_q;
        cur_val   = {7'b0, sel6[0]};
        elem_mask = 8'h01;
      end
    endcase
  end

  // Response value: read-back of truncated write data or current value, then extension
  always_comb begin
    new_val = we_q ? (wdata_q & elem_mask) : cur_val;
    if (addr_q == 3'd3) ext_val = {{6{new_val[1]}}, new_val[1:0]};
    else                ext_val = new_val;
  end

  // Scheduler next state: arbitration, capture, response latch
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    winner  = (req == 2'b11) ? rr_q : req[1];
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ACCESS;
          id_d    = winner;
          we_d    = winner ? req_we[1] : req_we[0];
          addr_d  = winner ? req_addr[5:3] : req_addr[2:0];
          idx_d   = winner ? req_idx[5:3] : req_idx[2:0];
          wdata_d = winner ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
          rr_d    = ~winner;
        end
      end
      ACCESS: begin
        state_d = RESP;
        err_d   = ~idx_ok;
        rdata_d = idx_ok ? ext_val : '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bank write: commits only on a legal write leaving ACCESS
  always_comb begin
    onebit_d  = onebit_q;
    onereg_d  = onereg_q;
    a_p1_d    = a_p1_q;
    a_sp1_d   = a_sp1_q;
    a_p21_d   = a_p21_q;
    a_u2_d    = a_u2_q;
    a_p1u1_d  = a_p1u1_q;
    a_p0u12_d = a_p0u12_q;
    if (state_q == ACCESS && we_q && idx_ok) begin
      case (addr_q)
        3'd0: onebit_d = wdata_q[0];
        3'd1: onereg_d = wdata_q[0];
        3'd2: a_p1_d   = wdata_q[1:0];
        3'd3: a_sp1_d  = wdata_q[1:0];
        3'd4: a_p21_d  = wdata_q[5:0];
        3'd5: a_u2_d   = (a_u2_q & ~(3'b001 << idx_q[1:0])) |
                         (3'(wdata_q[0]) << idx_q[1:0]);
        3'd6: a_p1u1_d = (a_p1u1_q & ~(4'b0011 << {idx_q[0], 1'b0})) |
                         ({2'b0, wdata_q[1:0]} << {idx_q[0], 1'b0});
        default: a_p0u12_d = (a_p0u12_q & ~(6'b000001 << idx_q)) |
                             (6'(wdata_q[0]) << idx_q);
      endcase
    end
  end

  // State, capture and bank registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      id_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      onebit_q  <= 1'b0;
      onereg_q  <= 1'b0;
      a_p1_q    <= 2'b10;
      a_sp1_q   <= '0;
      a_p21_q   <= '0;
      a_u2_q    <= '0;
      a_p1u1_q  <= '0;
      a_p0u12_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      onebit_q  <= onebit_d;
      onereg_q  <= onereg_d;
      a_p1_q    <= a_p1_d;
      a_sp1_q   <= a_sp1_d;
      a_p21_q   <= a_p21_d;
      a_u2_q    <= a_u2_d;
      a_p1u1_q  <= a_p1u1_d;
      a_p0u12_q <= a_p0u12_d;
    end
  end

  // Outputs decoded from state so reset clears them at once
  always_comb begin
    gnt       = (state_q == ACCESS) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid = (state_q == RESP);
    rsp_id    = (state_q == RESP) ? id_q : 1'b0;
    rsp_err   = (state_q == RESP) ? err_q : 1'b0;
    rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_var_bank_sched.sv
// Directed bench for var_bank_sched with hand-computed expectations.
module tb_var_bank_sched;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  req_we = '0;
  logic [5:0]  req_addr = '0;
  logic [5:0]  req_idx = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  gnt;
  logic        rsp_valid;
  logic        rsp_id;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int n_chk = 0;
  int n_pass = 0;

  var_bank_sched #(.DW(8)) dut (
    .clk(clk), .reset_l(reset_l), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_idx(req_idx), .req_wdata(req_wdata),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int id, input int we, input int addr, input int idx, input int wdata);
    req[id]                = 1'b1;
    req_we[id]             = we[0];
    req_addr[id*3 +: 3]    = addr[2:0];
    req_idx[id*3 +: 3]     = idx[2:0];
    req_wdata[id*8 +: 8]   = wdata[7:0];
  endtask

  // One full transaction; starts and ends with the DUT in IDLE
  task automatic txn(input string tag, input int id, input int we, input int addr,
                     input int idx, input int wdata, input int exp_rd, input int exp_err,
                     input bit garble = 1'b0);
    @(negedge clk);
    set_req(id, we, addr, idx, wdata);
    @(posedge clk); #1;
    check({tag, " gnt"}, 32'(gnt), (id != 0) ? 32'd2 : 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd1);
    req = '0;
    if (garble) req_wdata[id*8 +: 8] = ~wdata[7:0];
    @(posedge clk); #1;
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " rsp_id"}, 32'(rsp_id), 32'(id));
    check({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
    check({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, " gnt_resp"}, 32'(gnt), 32'd0);
    @(posedge clk); #1;
    check({tag, " idle"}, 32'({rsp_valid, busy}), 32'd0);
  endtask

  initial begin
    int cyc;
    bit saw_valid;

    repeat (2) @(posedge clk);
    #1;
    check("rst gnt", 32'(gnt), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_id", 32'(rsp_id), 32'd0);
    check("rst rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_l = 1'b1;

    // Both requesters held high: grants alternate 0,1,0,1... every 3 cycles
    @(negedge clk);
    set_req(0, 0, 2, 0, 0);
    set_req(1, 0, 2, 0, 0);
    for (int g = 0; g < 8; g++) begin
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (gnt == 2'b00 && cyc < 8);
      check($sformatf("arb%0d gnt", g), 32'(gnt), (g % 2 != 0) ? 32'd2 : 32'd1);
      check($sformatf("arb%0d spacing", g), 32'(cyc), (g == 0) ? 32'd1 : 32'd3);
    end
    req = '0;
    @(posedge clk); #1;
    check("arb last rsp_id", 32'(rsp_id), 32'd1);
    @(posedge clk); #1;

    txn("rd_a2", 0, 0, 2, 0, 0, 8'h02, 0);

    txn("wr_a3_ff", 1, 1, 3, 0, 8'hFF, 8'hFF, 0);
    txn("rd_a3_ff", 0, 0, 3, 0, 0, 8'hFF, 0);
    txn("wr_a3_01", 0, 1, 3, 0, 8'h01, 8'h01, 0);
    txn("rd_a3_01", 1, 0, 3, 0, 0, 8'h01, 0);
    txn("wr_a3_02", 0, 1, 3, 0, 8'h02, 8'hFE, 0);

    txn("wr_a7_i5", 0, 1, 7, 5, 8'h03, 8'h01, 0);
    txn("rd_a7_i6", 0, 0, 7, 6, 0, 0, 1);
    txn("wr_a7_i6", 1, 1, 7, 6, 8'h01, 0, 1);
    txn("rd_a7_i5", 1, 0, 7, 5, 0, 8'h01, 0);
    txn("rd_a7_i4", 0, 0, 7, 4, 0, 0, 0);
    txn("rd_a7_i0", 0, 0, 7, 0, 0, 0, 0);

    txn("rd_a0_i1", 0, 0, 0, 1, 0, 0, 1);
    txn("wr_a0", 0, 1, 0, 0, 8'hAB, 8'h01, 0);
    txn("rd_a0", 1, 0, 0, 0, 0, 8'h01, 0);
    txn("wr_a1", 1, 1, 1, 0, 8'hFE, 8'h00, 0);

    txn("wr_a5_i2", 0, 1, 5, 2, 8'h01, 8'h01, 0);
    txn("rd_a5_i1", 1, 0, 5, 1, 0, 0, 0);
    txn("rd_a5_i2", 1, 0, 5, 2, 0, 8'h01, 0);
    txn("rd_a5_i3", 0, 0, 5, 3, 0, 0, 1);

    txn("wr_a6_i1", 1, 1, 6, 1, 8'h0E, 8'h02, 0);
    txn("rd_a6_i0", 0, 0, 6, 0, 0, 0, 0);
    txn("rd_a6_i1", 0, 0, 6, 1, 0, 8'h02, 0);
    txn("rd_a6_i2", 1, 0, 6, 2, 0, 0, 1);

    txn("wr_a4_garble", 1, 1, 4, 0, 8'h15, 8'h15, 0, 1'b1);
    txn("rd_a4", 0, 0, 4, 0, 0, 8'h15, 0);
    txn("rd_a2_again", 1, 0, 2, 0, 0, 8'h02, 0);

    // Reset during the ACCESS cycle of a write to addr4
    @(negedge clk);
    set_req(0, 1, 4, 0, 8'h3F);
    @(posedge clk); #1;
    check("abort gnt", 32'(gnt), 32'd1);
    req = '0;
    reset_l = 1'b0;
    #1;
    check("abort gnt_rst", 32'(gnt), 32'd0);
    check("abort busy_rst", 32'(busy), 32'd0);
    check("abort valid_rst", 32'(rsp_valid), 32'd0);
    #1;
    reset_l = 1'b1;
    saw_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      saw_valid = saw_valid | rsp_valid | busy;
    end
    check("abort no_resp", 32'(saw_valid), 32'd0);
    txn("rd_a4_after_rst", 0, 0, 4, 0, 0, 8'h00, 0);
    txn("rd_a3_after_rst", 1, 0, 3, 0, 0, 8'h00, 0);

    // Pointer back to 0 after reset: simultaneous requests favor requester 0
    reset_l = 1'b0;
    #2;
    reset_l = 1'b1;
    @(negedge clk);
    set_req(0, 0, 2, 0, 0);
    set_req(1, 0, 2, 0, 0);
    @(posedge clk); #1;
    check("rst_rr gnt", 32'(gnt), 32'd1);
    req = '0;
    @(posedge clk); #1;
    check("rst_rr rdata", 32'(rsp_rdata), 32'd2);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
